kernel_weight_fetcher: RTL and testbench

Read-side controller for the kernel weight BRAM. On request it streams all KERNEL_SIZE*KERNEL_SIZE weight words of one input channel to the convolution datapath. Each word holds OUT_CHANNELS packed weights. It drives the BRAM port (en/we/addr), absorbs the BRAM's 1-cycle registered read latency, and presents a valid/ready stream with full backpressure support. It sits between the convolution controller (start/channel) and the kernel BRAM.

---
 rtl/conv_kernel_pkg.sv | 28 ++
 rtl/kernel_fetch_fifo.sv | 63 ++++++
 rtl/kernel_weight_fetcher.sv | 151 +++++++++++++++
 tb/tb_kernel_weight_fetcher.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_kernel_pkg.sv
// Shared types and helpers for the convolution kernel weight path.
package conv_kernel_pkg;

  localparam int unsigned DEF_KERNEL_WEIGHT_BITS = 6;
  localparam int unsigned DEF_KERNEL_SIZE        = 3;
  localparam int unsigned DEF_IN_CHANNELS        = 6;
  localparam int unsigned DEF_OUT_CHANNELS       = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  function automatic int unsigned kernel_positions(input int unsigned k);
    return k * k;
  endfunction

  // Extract weight field idx (channel 0 in the LSBs) from a packed word.
  function automatic logic [31:0] weight_field(input logic [255:0] word,
                                               input int unsigned  idx,
                                               input int unsigned  bits);
    logic [255:0] sh;
    sh = word >> (idx * bits);
    return 32'(sh) & ((32'd1 << bits) - 32'd1);
  endfunction

endpackage

// File: rtl/kernel_fetch_fifo.sv
// Two-entry register FIFO holding a weight word with its kernel position tags.
module kernel_fetch_fifo #(
  parameter int unsigned DATA_WIDTH = 36,
  parameter int unsigned POS_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic [POS_WIDTH-1:0]  push_kx_i,
  input  logic [POS_WIDTH-1:0]  push_ky_i,
  input  logic                  push_last_i,
  input  logic                  pop_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic [POS_WIDTH-1:0]  head_kx_o,
  output logic [POS_WIDTH-1:0]  head_ky_o,
  output logic                  head_last_o,
  output logic [1:0]            count_o
);

  logic [DATA_WIDTH-1:0] data_q [2];
  logic [POS_WIDTH-1:0]  kx_q   [2];
  logic [POS_WIDTH-1:0]  ky_q   [2];
  logic                  last_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q;

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        kx_q[i]   <= '0;
        ky_q[i]   <= '0;
        last_q[i] <= 1'b0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        data_q[wr_ptr_q] <= push_data_i;
        kx_q[wr_ptr_q]   <= push_kx_i;
        ky_q[wr_ptr_q]   <= push_ky_i;
        last_q[wr_ptr_q] <= push_last_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(push_i) - 2'(pop_i);
    end
  end

  assign valid_o     = (count_q != 2'd0);
  assign head_data_o = data_q[rd_ptr_q];
  assign head_kx_o   = kx_q[rd_ptr_q];
  assign head_ky_o   = ky_q[rd_ptr_q];
  assign head_last_o = last_q[rd_ptr_q];
  assign count_o     = count_q;

endmodule

// File: rtl/kernel_weight_fetcher.sv
// Streams the KERNEL_SIZE^2 weight words of one input channel from the kernel BRAM.
module kernel_weight_fetcher
  import conv_kernel_pkg::*;
#(
  parameter int unsigned KERNEL_WEIGHT_BITS = DEF_KERNEL_WEIGHT_BITS,
  parameter int unsigned KERNEL_SIZE        = DEF_KERNEL_SIZE,
  parameter int unsigned IN_CHANNELS        = DEF_IN_CHANNELS,
  parameter int unsigned OUT_CHANNELS       = DEF_OUT_CHANNELS,
  parameter int unsigned DATA_WIDTH         = KERNEL_WEIGHT_BITS * OUT_CHANNELS,
  parameter int unsigned ADDR_WIDTH         = (IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE > 1) ?
                                              $clog2(IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE) : 1,
  parameter int unsigned CH_WIDTH           = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1,
  parameter int unsigned POS_WIDTH          = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CH_WIDTH-1:0]   channel,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_data_in,
  input  logic [DATA_WIDTH-1:0] bram_data_out,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic [POS_WIDTH-1:0]  w_kx,
  output logic [POS_WIDTH-1:0]  w_ky,
  output logic                  w_last
);

  localparam int unsigned          KPOS    = kernel_positions(KERNEL_SIZE);
  localparam logic [POS_WIDTH-1:0] POS_MAX = POS_WIDTH'(KERNEL_SIZE - 1);

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [POS_WIDTH-1:0]  kx_q, kx_d, ky_q, ky_d;
  logic                  error_q, error_d;
  logic                  inflight_q;
  logic [POS_WIDTH-1:0]  infl_kx_q, infl_ky_q;
  logic                  infl_last_q;
  logic                  issue, last_pos, fifo_pop;
  logic [1:0]            fifo_count;

  assign last_pos = (kx_q == POS_MAX) && (ky_q == POS_MAX);

  // Next-state, read issue and done generation.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    kx_d    = kx_q;
    ky_d    = ky_q;
    error_d = 1'b0;
    issue   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (32'(channel) < IN_CHANNELS) begin
            base_d  = ADDR_WIDTH'(32'(channel) * KPOS);
            kx_d    = '0;
            ky_d    = '0;
            state_d = FETCH;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      FETCH: begin
        // Only issue when the read is guaranteed a FIFO slot on arrival.
        if (({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'd2) begin
          issue = 1'b1;
          if (last_pos) begin
            state_d = DRAIN;
          end else if (kx_q == POS_MAX) begin
            kx_d = '0;
            ky_d = ky_q + POS_WIDTH'(1);
          end else begin
            kx_d = kx_q + POS_WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        if ((fifo_count == 2'd0) && !inflight_q) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      kx_q        <= '0;
      ky_q        <= '0;
      error_q     <= 1'b0;
      inflight_q  <= 1'b0;
      infl_kx_q   <= '0;
      infl_ky_q   <= '0;
      infl_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      kx_q       <= kx_d;
      ky_q       <= ky_d;
      error_q    <= error_d;
      inflight_q <= issue;
      if (issue) begin
        infl_kx_q   <= kx_q;
        infl_ky_q   <= ky_q;
        infl_last_q <= last_pos;
      end
    end
  end

  assign busy         = (state_q != IDLE);
  assign error        = error_q;
  assign bram_en      = issue;
  assign bram_we      = 1'b0;
  assign bram_data_in = '0;
  assign bram_addr    = issue ? (base_q + ADDR_WIDTH'(ky_q) * ADDR_WIDTH'(KERNEL_SIZE)
                                 + ADDR_WIDTH'(kx_q)) : '0;
  assign fifo_pop     = w_valid & w_ready;

  kernel_fetch_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .POS_WIDTH (POS_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (inflight_q),
    .push_data_i(bram_data_out),
    .push_kx_i  (infl_kx_q),
    .push_ky_i  (infl_ky_q),
    .push_last_i(infl_last_q),
    .pop_i      (fifo_pop),
    .valid_o    (w_valid),
    .head_data_o(w_data),
    .head_kx_o  (w_kx),
    .head_ky_o  (w_ky),
    .head_last_o(w_last),
    .count_o    (fifo_count)
  );

endmodule

// File: tb/tb_kernel_weight_fetcher.sv
// Randomized self-checking bench for kernel_weight_fetcher with a behavioural BRAM.
module tb_kernel_weight_fetcher;

  localparam int K    = 3;
  localparam int KPOS = K * K;
  localparam int NCH  = 6;
  localparam int DW   = 36;
  localparam int AW   = 6;
  localparam int CW   = 3;
  localparam int PW   = 2;

  logic          clk, rst_n, start;
  logic [CW-1:0] channel;
  logic          busy, done, error, bram_en, bram_we, w_valid, w_ready, w_last;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_data_in, bram_data_out, w_data;
  logic [PW-1:0] w_kx, w_ky;

  logic [DW-1:0] mem [0:63];
  int checks = 0;
  int errors = 0;

  kernel_weight_fetcher dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .channel      (channel),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .bram_en      (bram_en),
    .bram_we      (bram_we),
    .bram_addr    (bram_addr),
    .bram_data_in (bram_data_in),
    .bram_data_out(bram_data_out),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .w_data       (w_data),
    .w_kx         (w_kx),
    .w_ky         (w_ky),
    .w_last       (w_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM with one-cycle registered read.
  always @(posedge clk) begin
    if (bram_en) bram_data_out <= mem[bram_addr];
  end

  function automatic logic ready_for(input int mode, input int cyc);
    case (mode)
      0: return 1'b1;
      1: return ((cyc % 4) == 0) || ((cyc % 4) == 3);
      2: return 1'($urandom_range(0, 1));
      3: return (cyc > 20);
      default: return 1'b1;
    endcase
  endfunction

  // Runs one fetch and checks it against the spec's word order; stops early after abort_after words.
  task automatic run_fetch(input int ch, input int mode, input int restart_cyc,
                           input int abort_after, output int first_valid);
    int base, issued, hs, last_hs;
    bit finished, prev_stall, rdy;
    logic [DW-1:0] prev_data;
    logic [PW-1:0] prev_kx, prev_ky;
    logic          prev_last;
    base = ch * KPOS; issued = 0; hs = 0; last_hs = -10;
    finished = 0; prev_stall = 0; first_valid = -1;
    prev_data = '0; prev_kx = '0; prev_ky = '0; prev_last = 1'b0;
    @(negedge clk);
    start = 1'b1; channel = CW'(ch); w_ready = ready_for(mode, 0);
    for (int cyc = 1; cyc <= 300 && !finished; cyc++) begin
      @(negedge clk);
      start = (cyc == restart_cyc);
      if (cyc == restart_cyc) channel = '0;
      checks++;
      if (busy !== 1'b1) begin
        errors++; $display("FAIL busy ch=%0d cyc=%0d got=%b want=1", ch, cyc, busy);
      end
      if (bram_en === 1'b1) begin
        checks++;
        if ((issued - hs) >= 2) begin
          errors++; $display("FAIL issue_rule ch=%0d cyc=%0d outstanding=%0d want<2", ch, cyc, issued - hs);
        end
        checks++;
        if (issued >= KPOS || bram_addr !== AW'(base + issued)) begin
          errors++; $display("FAIL bram_addr ch=%0d cyc=%0d got=%0d want=%0d (read %0d)", ch, cyc, bram_addr, base + issued, issued);
        end
      end
      if (prev_stall) begin
        checks++;
        if (w_valid !== 1'b1 || w_data !== prev_data || w_kx !== prev_kx ||
            w_ky !== prev_ky || w_last !== prev_last) begin
          errors++; $display("FAIL stall_stable ch=%0d cyc=%0d got v=%b d=%h want v=1 d=%h", ch, cyc, w_valid, w_data, prev_data);
        end
      end
      if (w_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (mode == 3 && cyc == 20) begin
        checks++;
        if (issued !== 2 || w_valid !== 1'b1 || w_data !== mem[base]) begin
          errors++; $display("FAIL long_stall reads=%0d v=%b d=%h want reads=2 v=1 d=%h", issued, w_valid, w_data, mem[base]);
        end
      end
      if (done === 1'b1) begin
        checks++;
        if (hs !== KPOS || last_hs !== cyc - 1) begin
          errors++; $display("FAIL done_timing ch=%0d cyc=%0d words=%0d last_hs=%0d want words=%0d last_hs=%0d", ch, cyc, hs, last_hs, KPOS, cyc - 1);
        end
        finished = 1;
      end
      rdy = ready_for(mode, cyc);
      w_ready = rdy;
      if (!finished && w_valid === 1'b1 && rdy) begin
        checks++;
        if (hs >= KPOS || w_data !== mem[base + hs] || w_kx !== PW'(hs % K) ||
            w_ky !== PW'(hs / K) || w_last !== (hs == KPOS - 1)) begin
          errors++; $display("FAIL word ch=%0d idx=%0d got d=%h kx=%0d ky=%0d last=%b want d=%h kx=%0d ky=%0d last=%b",
                             ch, hs, w_data, w_kx, w_ky, w_last, mem[(base + hs) % 64], hs % K, hs / K, hs == KPOS - 1);
        end
        hs++;
        last_hs = cyc;
        if (hs == abort_after) finished = 1;
      end
      prev_stall = (w_valid === 1'b1) && !rdy;
      prev_data = w_data; prev_kx = w_kx; prev_ky = w_ky; prev_last = w_last;
      if (bram_en === 1'b1) issued++;
    end
    start = 1'b0;
    if (!finished) begin
      checks++; errors++;
      $display("FAIL timeout ch=%0d words=%0d want=%0d", ch, hs, KPOS);
    end
  endtask

  task automatic check_idle_after(input int ch);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL idle_after ch=%0d busy=%b done=%b want 0 0", ch, busy, done);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, error, bram_en, bram_we, w_valid, w_last} !== 7'b0 ||
        bram_addr !== '0 || bram_data_in !== '0 || w_data !== '0 || w_kx !== '0 || w_ky !== '0) begin
      errors++; $display("FAIL reset_outputs got busy=%b en=%b v=%b d=%h want all 0", busy, bram_en, w_valid, w_data);
    end
  endtask

  task automatic test_basic_stream();
    int fv;
    run_fetch(2, 0, -1, -1, fv);
    checks++;
    if (fv !== 3) begin
      errors++; $display("FAIL first_valid got=%0d want=3", fv);
    end
    check_idle_after(2);
  endtask

  task automatic test_backpressure();
    int fv;
    run_fetch(5, 1, -1, -1, fv);
    check_idle_after(5);
  endtask

  task automatic test_bad_channel();
    for (int c = NCH; c < 8; c++) begin
      @(negedge clk);
      start = 1'b1; channel = CW'(c);
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (error !== 1'b1 || busy !== 1'b0 || bram_en !== 1'b0 || w_valid !== 1'b0) begin
        errors++; $display("FAIL error_pulse ch=%0d err=%b busy=%b en=%b v=%b want 1 0 0 0", c, error, busy, bram_en, w_valid);
      end
      @(negedge clk);
      checks++;
      if (error !== 1'b0 || busy !== 1'b0 || bram_en !== 1'b0) begin
        errors++; $display("FAIL error_width ch=%0d err=%b busy=%b want 0 0", c, error, busy);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int fv;
    run_fetch(3, 0, 4, -1, fv);
    check_idle_after(3);
  endtask

  task automatic test_reset_mid_fetch();
    int fv;
    run_fetch(4, 2, -1, 4, fv);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, error, bram_en, w_valid, w_last} !== 6'b0 || bram_addr !== '0 ||
        w_data !== '0 || w_kx !== '0 || w_ky !== '0) begin
      errors++; $display("FAIL mid_reset busy=%b done=%b en=%b v=%b d=%h want all 0", busy, done, bram_en, w_valid, w_data);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL reset_no_done i=%0d done=%b busy=%b want 0 0", i, done, busy);
      end
    end
    rst_n = 1'b1;
    run_fetch(1, 0, -1, -1, fv);
    check_idle_after(1);
  endtask

  task automatic test_long_stall();
    int fv;
    run_fetch(0, 3, -1, -1, fv);
    check_idle_after(0);
  endtask

  task automatic test_back_to_back();
    int fv;
    for (int n = 0; n < 6; n++) begin
      run_fetch(int'($urandom_range(0, NCH - 1)), 2, -1, -1, fv);
    end
    check_idle_after(-1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; channel = '0; w_ready = 1'b0;
    for (int a = 0; a < 64; a++) mem[a] = {30'($urandom), 6'(a)};
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic_stream();
    test_backpressure();
    test_bad_channel();
    test_start_while_busy();
    test_reset_mid_fetch();
    test_long_stall();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
